// File: rtl/prog_mem_pkg.sv
// Shared types and helpers for the loadable instruction memory.
package prog_mem_pkg;

   localparam logic [31:0] NOP_WORD = 32'h0000_0000;

   typedef enum logic {CLEAR, READY} pm_state_t;

   typedef struct packed {
      logic        fault;
      logic [31:0] idx;
   } pc_map_t;

   // Word index plus range/alignment fault for a PC; idx is masked to addr_w bits.
   function automatic pc_map_t pc_map(input logic [63:0] pc, input int addr_w, input bit byte_addr);
      pc_map_t     r;
      logic [63:0] word;
      word    = byte_addr ? (pc >> 2) : pc;
      r.idx   = word[31:0] & ((32'd1 << addr_w) - 32'd1);
      r.fault = ((word >> addr_w) != 64'd0) || (byte_addr && (pc[1:0] != 2'b00));
      return r;
   endfunction

endpackage

// File: rtl/prog_mem_if.sv
// Fetch and loader bus between the fetch stage / loader and prog_mem.
interface prog_mem_if #(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 8,
   parameter int PC_W   = 32
);
   logic              fetch_req;
   logic [PC_W-1:0]   fetch_pc;
   logic              stall;
   logic [DATA_W-1:0] instr;
   logic              instr_valid;
   logic              addr_fault;
   logic              ready;
   logic              load_we;
   logic [ADDR_W-1:0] load_addr;
   logic [DATA_W-1:0] load_data;

   modport master (
      output fetch_req, fetch_pc, stall, load_we, load_addr, load_data,
      input  instr, instr_valid, addr_fault, ready
   );

   modport slave (
      input  fetch_req, fetch_pc, stall, load_we, load_addr, load_data,
      output instr, instr_valid, addr_fault, ready
   );
endinterface

// File: rtl/prog_mem_array.sv
// Simple dual-port RAM: one synchronous read-first port, one write port.
module prog_mem_array #(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              we,
   input  logic [ADDR_W-1:0] wa,
   input  logic [DATA_W-1:0] wd,
   input  logic              re,
   input  logic [ADDR_W-1:0] ra,
   output logic [DATA_W-1:0] rd
);
   logic [DATA_W-1:0] mem [2**ADDR_W];

   always_ff @(posedge clk) begin
      if (we) mem[wa] <= wd;
   end

   // Only the read register resets; the array itself keeps no reset.
   always_ff @(posedge clk) begin
      if (rst)     rd <= '0;
      else if (re) rd <= mem[ra];
   end
endmodule

// File: rtl/prog_mem.sv
// Loadable instruction memory with registered fetch, stall hold and reset-time clear.
//  state | meaning
//  CLEAR | clr_idx sweeps the array writing FILL_WORD; fetches and loads refused
//  READY | normal fetch and load operation
module prog_mem
   import prog_mem_pkg::*;
#(
   parameter int                DATA_W       = 32,
   parameter int                ADDR_W       = 8,
   parameter int                PC_W         = 32,
   parameter int                BYTE_ADDR    = 0,
   parameter int                CLEAR_ON_RST = 1,
   parameter logic [DATA_W-1:0] FILL_WORD    = DATA_W'(NOP_WORD)
) (
   input  logic        clk,
   input  logic        rst,
   prog_mem_if.slave   bus
);
   localparam int DEPTH = 2**ADDR_W;

   pm_state_t         state;
   logic [ADDR_W-1:0] clr_idx;
   logic              fill_sel;
   logic              valid_q;
   logic              fault_q;
   pc_map_t           pm;
   logic              unused_idx;
   logic              rdy;
   logic              accept;
   logic              mem_we;
   logic [ADDR_W-1:0] mem_wa;
   logic [DATA_W-1:0] mem_wd;
   logic [DATA_W-1:0] rd_data;

   always_comb begin
      pm     = pc_map(64'(bus.fetch_pc), ADDR_W, BYTE_ADDR != 0);
      rdy    = (state == READY);
      accept = bus.fetch_req && rdy && !bus.stall;
      mem_we = (state == CLEAR) || (rdy && bus.load_we);
      mem_wa = (state == CLEAR) ? clr_idx : bus.load_addr;
      mem_wd = (state == CLEAR) ? FILL_WORD : bus.load_data;
   end

   assign unused_idx = ^pm.idx[31:ADDR_W];

   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= (CLEAR_ON_RST != 0) ? CLEAR : READY;
         clr_idx <= '0;
      end else if (state == CLEAR) begin
         if (clr_idx == ADDR_W'(DEPTH - 1)) state <= READY;
         clr_idx <= clr_idx + 1'b1;
      end
   end

   // fill_sel remembers whether the last accepted fetch faulted, so instr holds across idle cycles.
   always_ff @(posedge clk) begin
      if (rst) begin
         valid_q  <= 1'b0;
         fault_q  <= 1'b0;
         fill_sel <= 1'b0;
      end else if (!bus.stall) begin
         valid_q <= accept;
         fault_q <= accept && pm.fault;
         if (accept) fill_sel <= pm.fault;
      end
   end

   prog_mem_array #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_array (
      .clk (clk),
      .rst (rst),
      .we  (mem_we),
      .wa  (mem_wa),
      .wd  (mem_wd),
      .re  (accept && !pm.fault),
      .ra  (pm.idx[ADDR_W-1:0]),
      .rd  (rd_data)
   );

   assign bus.instr       = fill_sel ? FILL_WORD : rd_data;
   assign bus.instr_valid = valid_q;
   assign bus.addr_fault  = fault_q;
   assign bus.ready       = rdy;
endmodule

// File: tb/tb_prog_mem.sv
// Self-checking bench for prog_mem: word-indexed cleared instance plus byte-addressed retained instance.
module tb_prog_mem;
   logic clk = 1'b0;
   logic rst = 1'b0;
   always #5 clk = ~clk;

   prog_mem_if #(.DATA_W(32), .ADDR_W(4), .PC_W(32)) ia ();
   prog_mem_if #(.DATA_W(32), .ADDR_W(8), .PC_W(32)) ib ();

   prog_mem #(.DATA_W(32), .ADDR_W(4), .PC_W(32), .BYTE_ADDR(0), .CLEAR_ON_RST(1))
      dut_a (.clk(clk), .rst(rst), .bus(ia));
   prog_mem #(.DATA_W(32), .ADDR_W(8), .PC_W(32), .BYTE_ADDR(1), .CLEAR_ON_RST(0))
      dut_b (.clk(clk), .rst(rst), .bus(ib));

   int checks = 0;
   int failures = 0;

   typedef struct {
      logic        we;
      logic [3:0]  la;
      logic [31:0] ld;
      logic        req;
      logic [31:0] pc;
      logic        st;
      logic [31:0] ei;
      logic        ev;
      logic        ef;
   } vec_t;

   vec_t        tbl[16];
   logic [31:0] mem_m[16];
   logic [31:0] m_instr;
   logic        m_valid, m_fault;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_a();
      ia.fetch_req = 0; ia.fetch_pc = '0; ia.stall = 0;
      ia.load_we = 0; ia.load_addr = '0; ia.load_data = '0;
   endtask

   task automatic idle_b();
      ib.fetch_req = 0; ib.fetch_pc = '0; ib.stall = 0;
      ib.load_we = 0; ib.load_addr = '0; ib.load_data = '0;
   endtask

   // Counts samples with ready low (first sample is the cycle after the reset edge);
   // optionally issues a load to index 2 at the tenth low sample.
   task automatic count_clear(output int n, input bit inject);
      n = 0;
      while (!ia.ready && n < 40) begin
         n++;
         if (inject && n == 10) begin
            ia.load_we = 1; ia.load_addr = 4'd2; ia.load_data = 32'hDEAD_BEEF;
         end
         tick();
         ia.load_we = 0;
      end
   endtask

   function automatic vec_t row(input logic we, input logic [3:0] la, input logic [31:0] ld,
                                input logic req, input logic [31:0] pc, input logic st,
                                input logic [31:0] ei, input logic ev, input logic ef);
      vec_t v;
      v.we = we; v.la = la; v.ld = ld; v.req = req; v.pc = pc; v.st = st;
      v.ei = ei; v.ev = ev; v.ef = ef;
      return v;
   endfunction

   initial begin
      int n;
      idle_a();
      idle_b();

      // Reset and initial clear
      rst = 1; tick(); rst = 0;
      chk("rst_instr", ia.instr, 32'h0);
      chk("rst_valid", 32'(ia.instr_valid), 32'h0);
      chk("rst_fault", 32'(ia.addr_fault), 32'h0);
      chk("rst_ready_a", 32'(ia.ready), 32'h0);
      chk("rst_ready_b", 32'(ib.ready), 32'h1);
      count_clear(n, 1'b0);
      chk("clear_len", 32'(n), 32'd16);
      for (int i = 0; i < 16; i++) mem_m[i] = 32'h0;

      ia.fetch_req = 1; ia.fetch_pc = 32'd5; tick(); idle_a();
      chk("clr_fetch_instr", ia.instr, 32'h0);
      chk("clr_fetch_valid", 32'(ia.instr_valid), 32'h1);

      // Directed table on the word-indexed instance
      tbl[0]  = row(1, 4'd1, 32'h0022_1820, 0, 32'd0, 0, 32'h0, 0, 0);
      tbl[1]  = row(0, 4'd0, 32'h0,         1, 32'd1, 0, 32'h0022_1820, 1, 0);
      tbl[2]  = row(1, 4'd3, 32'hAAAA_AAAA, 0, 32'd0, 0, 32'h0022_1820, 0, 0);
      tbl[3]  = row(1, 4'd3, 32'h5555_5555, 1, 32'd3, 0, 32'hAAAA_AAAA, 1, 0);
      tbl[4]  = row(0, 4'd0, 32'h0,         1, 32'd3, 0, 32'h5555_5555, 1, 0);
      tbl[5]  = row(0, 4'd0, 32'h0,         1, 32'd16, 0, 32'h0, 1, 1);
      tbl[6]  = row(0, 4'd0, 32'h0,         0, 32'd0, 0, 32'h0, 0, 0);
      tbl[7]  = row(1, 4'd2, 32'h1234_5678, 0, 32'd0, 0, 32'h0, 0, 0);
      tbl[8]  = row(0, 4'd0, 32'h0,         1, 32'd1, 0, 32'h0022_1820, 1, 0);
      tbl[9]  = row(0, 4'd0, 32'h0,         1, 32'd2, 1, 32'h0022_1820, 1, 0);
      tbl[10] = row(0, 4'd0, 32'h0,         1, 32'd2, 1, 32'h0022_1820, 1, 0);
      tbl[11] = row(0, 4'd0, 32'h0,         1, 32'd2, 1, 32'h0022_1820, 1, 0);
      tbl[12] = row(0, 4'd0, 32'h0,         1, 32'd2, 0, 32'h1234_5678, 1, 0);
      tbl[13] = row(0, 4'd0, 32'h0,         1, 32'h8000_0000, 0, 32'h0, 1, 1);
      tbl[14] = row(0, 4'd0, 32'h0,         0, 32'd0, 1, 32'h0, 1, 1);
      tbl[15] = row(0, 4'd0, 32'h0,         0, 32'd0, 0, 32'h0, 0, 0);
      for (int i = 0; i < 16; i++) begin
         ia.load_we = tbl[i].we; ia.load_addr = tbl[i].la; ia.load_data = tbl[i].ld;
         ia.fetch_req = tbl[i].req; ia.fetch_pc = tbl[i].pc; ia.stall = tbl[i].st;
         tick();
         if (tbl[i].we) mem_m[tbl[i].la] = tbl[i].ld;
         chk($sformatf("tbl%0d_instr", i), ia.instr, tbl[i].ei);
         chk($sformatf("tbl%0d_valid", i), 32'(ia.instr_valid), 32'(tbl[i].ev));
         chk($sformatf("tbl%0d_fault", i), 32'(ia.addr_fault), 32'(tbl[i].ef));
         m_instr = tbl[i].ei; m_valid = tbl[i].ev; m_fault = tbl[i].ef;
      end
      idle_a();

      // Randomised traffic against an array-based reference
      for (int c = 0; c < 400; c++) begin
         logic        we, req, st;
         logic [3:0]  la;
         logic [31:0] ld, pc;
         we  = ($urandom_range(0, 2) == 0);
         la  = 4'($urandom_range(0, 15));
         ld  = $urandom;
         req = ($urandom_range(0, 3) != 0);
         st  = ($urandom_range(0, 4) == 0);
         pc  = ($urandom_range(0, 9) == 0) ? $urandom : 32'($urandom_range(0, 17));
         ia.load_we = we; ia.load_addr = la; ia.load_data = ld;
         ia.fetch_req = req; ia.fetch_pc = pc; ia.stall = st;
         if (!st) begin
            if (req) begin
               m_fault = (pc > 32'd15);
               m_instr = m_fault ? 32'h0 : mem_m[pc[3:0]];
               m_valid = 1;
            end else begin
               m_valid = 0;
               m_fault = 0;
            end
         end
         tick();
         if (we) mem_m[la] = ld;
         chk("rnd_instr", ia.instr, m_instr);
         chk("rnd_valid", 32'(ia.instr_valid), 32'(m_valid));
         chk("rnd_fault", 32'(ia.addr_fault), 32'(m_fault));
      end
      idle_a();
      tick();

      // Byte-addressed instance with retained contents
      ib.load_we = 1; ib.load_addr = 8'd2;   ib.load_data = 32'h0000_B2B2; tick();
      ib.load_addr = 8'd255; ib.load_data = 32'h0000_FFEE; tick();
      ib.load_we = 0;
      ib.fetch_req = 1; ib.fetch_pc = 32'h8; tick();
      chk("b_pc8_instr", ib.instr, 32'h0000_B2B2);
      chk("b_pc8_fault", 32'(ib.addr_fault), 32'h0);
      ib.fetch_pc = 32'h6; tick();
      chk("b_pc6_fault", 32'(ib.addr_fault), 32'h1);
      chk("b_pc6_instr", ib.instr, 32'h0);
      chk("b_pc6_valid", 32'(ib.instr_valid), 32'h1);
      ib.fetch_pc = 32'h3FC; tick();
      chk("b_top_instr", ib.instr, 32'h0000_FFEE);
      chk("b_top_fault", 32'(ib.addr_fault), 32'h0);
      ib.fetch_pc = 32'h400; tick();
      chk("b_oor_fault", 32'(ib.addr_fault), 32'h1);
      chk("b_oor_instr", ib.instr, 32'h0);
      idle_b();

      // Reset mid-clear restarts the sweep; loads during clear are dropped
      ia.load_we = 1; ia.load_addr = 4'd7; ia.load_data = 32'h7777_7777; tick(); idle_a();
      rst = 1; tick(); rst = 0;
      for (int i = 0; i < 7; i++) tick();
      chk("midclr_ready", 32'(ia.ready), 32'h0);
      rst = 1; tick(); rst = 0;
      count_clear(n, 1'b1);
      chk("restart_len", 32'(n), 32'd16);
      chk("restart_ready", 32'(ia.ready), 32'h1);
      ia.fetch_req = 1; ia.fetch_pc = 32'd2; tick();
      chk("drop_load_instr", ia.instr, 32'h0);
      chk("drop_load_valid", 32'(ia.instr_valid), 32'h1);
      ia.fetch_pc = 32'd7; tick();
      chk("cleared_idx7", ia.instr, 32'h0);
      idle_a();
      tick();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
